// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: register numbers, addressing modes, FSM states and step helper for operand fetch
package operand_fetch_pkg;
  localparam logic [3:0] REG_PC  = 4'd0;
  localparam logic [3:0] REG_SP  = 4'd1;
  localparam logic [3:0] REG_SR  = 4'd2;
  localparam logic [3:0] REG_CG1 = 4'd2;
  localparam logic [3:0] REG_CG2 = 4'd3;
  localparam logic [1:0] REGISTER               = 2'd0;
  localparam logic [1:0] INDEXED                = 2'd1;
  localparam logic [1:0] INDIRECT               = 2'd2;
  localparam logic [1:0] INDIRECT_AUTOINCREMENT = 2'd3;
  typedef enum logic [2:0] {IDLE, SRC_EXT, SRC_RD, DST_EXT, DST_RD, DONE} state_t;
  // PC and SP stay word aligned even for byte accesses
  function automatic logic [1:0] ainc_step_f(input logic bw, input logic [3:0] r);
    return (bw && r != REG_PC && r != REG_SP) ? 2'd1 : 2'd2;
  endfunction
endpackage

// File: rtl/operand_ea_calc.sv
// operand_ea_calc: effective address = base (PC, zero for SR-absolute, or register) + extension word
module operand_ea_calc
  import operand_fetch_pkg::*;
(
  input  logic [3:0]  reg_i,
  input  logic [15:0] reg_val_i,
  input  logic [15:0] pc_val_i,
  input  logic [15:0] x_i,
  output logic [15:0] ea_o
);
  logic [15:0] base;
  always_comb base = reg_i == REG_PC ? pc_val_i : reg_i == REG_SR ? 16'd0 : reg_val_i;
  assign ea_o = base + x_i;
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: MSP430 operand sequencer fetching extension words and memory operands for the ALU
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        Format,
  input  logic        BW,
  input  logic [3:0]  srcA,
  input  logic [3:0]  dstA,
  input  logic [1:0]  As,
  input  logic        Ad,
  input  logic        srcGenerated,
  input  logic        dstGenerated,
  input  logic [15:0] src_cg,
  input  logic [15:0] dst_cg,
  input  logic [15:0] rsrc_val,
  input  logic [15:0] rdst_val,
  input  logic [15:0] pc_val,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        pc_inc,
  output logic        ainc_en,
  output logic [3:0]  ainc_reg,
  output logic [1:0]  ainc_step,
  output logic [15:0] src_op,
  output logic [15:0] dst_op,
  output logic [15:0] dst_addr,
  output logic        dst_is_mem,
  output logic        busy,
  output logic        done
);
  state_t      state_q, state_d;
  logic        fmt_q, fmt_d, imm_q, imm_d, dext_q, dext_d, ainc_q, ainc_d, dst_is_mem_q, dst_is_mem_d;
  logic [3:0]  sreg_q, sreg_d, dreg_q, dreg_d, ainc_reg_q, ainc_reg_d;
  logic [1:0]  ainc_step_q, ainc_step_d;
  logic [15:0] addr_q, addr_d, src_op_q, src_op_d, dst_op_q, dst_op_d, dst_addr_q, dst_addr_d;
  logic        s_cg, s_ext, s_rd, d_ext, rdy;
  logic [3:0]  s_reg;
  logic [15:0] s_val, s_cgv, live_s, ea, op_v;
  // Format 1 routes its single operand through the source phase using dstA
  assign s_cg   = Format ? dstGenerated : srcGenerated;
  assign s_reg  = Format ? dstA : srcA;
  assign s_val  = Format ? rdst_val : rsrc_val;
  assign s_cgv  = Format ? dst_cg : src_cg;
  assign s_ext  = !s_cg && (As == INDEXED || (As == INDIRECT_AUTOINCREMENT && s_reg == REG_PC));
  assign s_rd   = !s_cg && As != REGISTER && !(As == INDIRECT_AUTOINCREMENT && s_reg == REG_PC);
  assign d_ext  = !Format && !dstGenerated && Ad;
  assign live_s = fmt_q ? rdst_val : rsrc_val;
  assign rdy    = mem_rd && mem_ready;
  operand_ea_calc u_ea (
    .reg_i    (state_q == DST_EXT ? dreg_q : sreg_q),
    .reg_val_i(state_q == DST_EXT ? rdst_val : live_s),
    .pc_val_i (pc_val),
    .x_i      (mem_rdata),
    .ea_o     (ea)
  );
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = s_ext ? SRC_EXT : s_rd ? SRC_RD : d_ext ? DST_EXT : DONE;
      SRC_EXT: if (mem_ready) state_d = !imm_q ? SRC_RD : dext_q ? DST_EXT : DONE;
      SRC_RD:  if (mem_ready) state_d = dext_q ? DST_EXT : DONE;
      DST_EXT: if (mem_ready) state_d = DST_RD;
      DST_RD:  if (mem_ready) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    mem_rd     = state_q inside {SRC_EXT, SRC_RD, DST_EXT, DST_RD};
    mem_addr   = (state_q == SRC_EXT || state_q == DST_EXT) ? pc_val : mem_rd ? addr_q : 16'd0;
    pc_inc     = !rst && rdy && (state_q == SRC_EXT || state_q == DST_EXT);
    ainc_en    = !rst && rdy && state_q == SRC_RD && ainc_q;
    busy       = state_q != IDLE;
    done       = state_q == DONE;
    ainc_reg   = ainc_reg_q;
    ainc_step  = ainc_step_q;
    src_op     = src_op_q;
    dst_op     = dst_op_q;
    dst_addr   = dst_addr_q;
    dst_is_mem = dst_is_mem_q;
  end
  always_comb begin
    fmt_d        = fmt_q;
    imm_d        = imm_q;
    dext_d       = dext_q;
    ainc_d       = ainc_q;
    sreg_d       = sreg_q;
    dreg_d       = dreg_q;
    ainc_reg_d   = ainc_reg_q;
    ainc_step_d  = ainc_step_q;
    addr_d       = addr_q;
    src_op_d     = src_op_q;
    dst_op_d     = dst_op_q;
    dst_addr_d   = dst_addr_q;
    dst_is_mem_d = dst_is_mem_q;
    op_v         = s_cg ? s_cgv : s_val;
    if (state_q == IDLE && start) begin
      fmt_d        = Format;
      sreg_d       = s_reg;
      dreg_d       = dstA;
      imm_d        = s_ext && As == INDIRECT_AUTOINCREMENT;
      dext_d       = d_ext;
      ainc_d       = s_rd && As == INDIRECT_AUTOINCREMENT;
      ainc_reg_d   = ainc_d ? s_reg : 4'd0;
      ainc_step_d  = ainc_d ? ainc_step_f(BW, s_reg) : 2'd0;
      addr_d       = s_val;
      src_op_d     = (!Format && (s_cg || As == REGISTER)) ? op_v : 16'd0;
      dst_op_d     = Format ? ((s_cg || As == REGISTER) ? op_v : 16'd0) : dstGenerated ? dst_cg : rdst_val;
      dst_addr_d   = (Format && s_rd && !s_ext) ? s_val : 16'd0;
      dst_is_mem_d = Format ? (!s_cg && As != REGISTER) : d_ext;
    end else if (rdy && state_q == SRC_EXT) begin
      if (imm_q) begin
        if (fmt_q) begin
          dst_op_d   = mem_rdata;
          dst_addr_d = pc_val;
        end else
          src_op_d = mem_rdata;
      end else begin
        addr_d = ea;
        if (fmt_q) dst_addr_d = ea;
      end
    end else if (rdy && state_q == SRC_RD) begin
      if (fmt_q) dst_op_d = mem_rdata;
      else src_op_d = mem_rdata;
    end else if (rdy && state_q == DST_EXT) begin
      addr_d     = ea;
      dst_addr_d = ea;
    end else if (rdy && state_q == DST_RD)
      dst_op_d = mem_rdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fmt_q        <= 1'b0;
      imm_q        <= 1'b0;
      dext_q       <= 1'b0;
      ainc_q       <= 1'b0;
      sreg_q       <= 4'd0;
      dreg_q       <= 4'd0;
      ainc_reg_q   <= 4'd0;
      ainc_step_q  <= 2'd0;
      addr_q       <= 16'd0;
      src_op_q     <= 16'd0;
      dst_op_q     <= 16'd0;
      dst_addr_q   <= 16'd0;
      dst_is_mem_q <= 1'b0;
    end else begin
      fmt_q        <= fmt_d;
      imm_q        <= imm_d;
      dext_q       <= dext_d;
      ainc_q       <= ainc_d;
      sreg_q       <= sreg_d;
      dreg_q       <= dreg_d;
      ainc_reg_q   <= ainc_reg_d;
      ainc_step_q  <= ainc_step_d;
      addr_q       <= addr_d;
      src_op_q     <= src_op_d;
      dst_op_q     <= dst_op_d;
      dst_addr_q   <= dst_addr_d;
      dst_is_mem_q <= dst_is_mem_d;
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed operand fetch scenarios with a memory responder and expectation queue
module tb_operand_fetch;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, Format = 1'b0, BW = 1'b0, Ad = 1'b0;
  logic [3:0]  srcA = 4'd0, dstA = 4'd0;
  logic [1:0]  As = 2'd0;
  logic        srcGenerated = 1'b0, dstGenerated = 1'b0;
  logic [15:0] src_cg = 16'd0, dst_cg = 16'd0, rsrc_val = 16'd0, rdst_val = 16'd0, pc_val = 16'd0;
  logic [15:0] mem_addr, mem_rdata = 16'd0;
  logic        mem_rd, mem_ready = 1'b0, pc_inc, ainc_en;
  logic [3:0]  ainc_reg;
  logic [1:0]  ainc_step;
  logic [15:0] src_op, dst_op, dst_addr;
  logic        dst_is_mem, busy, done;
  typedef struct {
    string tag;
    logic [15:0] src, dst, daddr;
    logic dmem;
    int lat, npc, nai, nrd;
  } exp_t;
  exp_t sb[$];
  logic [15:0] mem [logic [15:0]];
  logic [15:0] rd_log[$];
  logic [15:0] got_src, got_dst, got_daddr, held_addr;
  logic [3:0]  ai_reg;
  logic [1:0]  ai_step;
  logic        got_dmem, got_busy, done_now, held, pc_adv;
  int total = 0, bad = 0, delay = 0, wcnt = 0;
  int pc_cnt, ai_cnt, overlap, unstable, rd_cycles;
  operand_fetch dut (
    .clk(clk), .rst(rst), .start(start), .Format(Format), .BW(BW), .srcA(srcA), .dstA(dstA),
    .As(As), .Ad(Ad), .srcGenerated(srcGenerated), .dstGenerated(dstGenerated),
    .src_cg(src_cg), .dst_cg(dst_cg), .rsrc_val(rsrc_val), .rdst_val(rdst_val), .pc_val(pc_val),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc_inc(pc_inc), .ainc_en(ainc_en), .ainc_reg(ainc_reg), .ainc_step(ainc_step),
    .src_op(src_op), .dst_op(dst_op), .dst_addr(dst_addr), .dst_is_mem(dst_is_mem),
    .busy(busy), .done(done)
  );
  initial forever #5 clk = ~clk;
  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // one clock: respond to reads at negedge, observe, then advance the PC model after the edge
  task automatic step();
    @(negedge clk);
    if (mem_rd && !rst) begin
      mem_ready = wcnt >= delay;
      mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 16'hDEAD;
    end else begin
      mem_ready = 1'b0;
      mem_rdata = 16'd0;
    end
    #1;
    done_now = done;
    if (mem_rd) begin
      rd_cycles++;
      if (held && mem_addr !== held_addr) unstable++;
      held = !mem_ready;
      held_addr = mem_addr;
      if (mem_ready) rd_log.push_back(mem_addr);
      wcnt = mem_ready ? 0 : wcnt + 1;
    end else begin
      held = 1'b0;
      wcnt = 0;
    end
    if (pc_inc && ainc_en) overlap++;
    if (pc_inc) pc_cnt++;
    if (ainc_en) begin
      ai_cnt++;
      ai_reg = ainc_reg;
      ai_step = ainc_step;
    end
    pc_adv = pc_inc;
    if (done) begin
      got_src = src_op;
      got_dst = dst_op;
      got_daddr = dst_addr;
      got_dmem = dst_is_mem;
      got_busy = busy;
    end
    @(posedge clk);
    #1;
    if (pc_adv) pc_val = pc_val + 16'd2;
  endtask
  task automatic set_in(input logic f, bw, input logic [3:0] sa, da, input logic [1:0] as, input logic ad,
                        input logic sg, dg, input logic [15:0] scg, dcg, rs, rd, pc);
    Format = f; BW = bw; srcA = sa; dstA = da; As = as; Ad = ad;
    srcGenerated = sg; dstGenerated = dg; src_cg = scg; dst_cg = dcg;
    rsrc_val = rs; rdst_val = rd; pc_val = pc;
  endtask
  task automatic run(input string tag, input logic [15:0] es, ed, ea, input logic em,
                     input int lat, npc, nai, nrd, input logic hold);
    exp_t e;
    int c;
    e = '{tag: tag, src: es, dst: ed, daddr: ea, dmem: em, lat: lat, npc: npc, nai: nai, nrd: nrd};
    sb.push_back(e);
    pc_cnt = 0; ai_cnt = 0; overlap = 0; unstable = 0; rd_cycles = 0; ai_reg = 0; ai_step = 0;
    rd_log.delete();
    start = 1'b1;
    step();
    if (!hold) start = 1'b0;
    c = 0;
    done_now = 1'b0;
    while (!done_now && c < 60) begin
      step();
      c++;
    end
    start = 1'b0;
    e = sb.pop_front();
    chk({e.tag, ".done_seen"}, done_now, 1);
    chk({e.tag, ".src_op"}, got_src, e.src);
    chk({e.tag, ".dst_op"}, got_dst, e.dst);
    chk({e.tag, ".dst_addr"}, got_daddr, e.daddr);
    chk({e.tag, ".dst_is_mem"}, got_dmem, e.dmem);
    chk({e.tag, ".busy_at_done"}, got_busy, 1);
    chk({e.tag, ".latency"}, c, e.lat);
    chk({e.tag, ".pc_inc_count"}, pc_cnt, e.npc);
    chk({e.tag, ".ainc_count"}, ai_cnt, e.nai);
    chk({e.tag, ".reads"}, rd_log.size(), e.nrd);
    chk({e.tag, ".pulse_overlap"}, overlap, 0);
    chk({e.tag, ".idle_after"}, {busy, done, mem_rd}, 0);
  endtask
  initial begin
    mem[16'h1000] = 16'h1234;
    mem[16'h2000] = 16'h0010; mem[16'h0200] = 16'h00AB; mem[16'h0310] = 16'h7777;
    mem[16'h3000] = 16'h0400; mem[16'h0400] = 16'hBEEF;
    mem[16'h4000] = 16'h0004; mem[16'h0002] = 16'h2222;
    mem[16'h5000] = 16'h0100; mem[16'h5100] = 16'h5151;
    mem[16'h0A00] = 16'h0AAA;
    mem[16'h6000] = 16'h0020; mem[16'h6002] = 16'h0030; mem[16'h0120] = 16'h1111; mem[16'h0230] = 16'h2323;
    step();
    step();
    chk("reset_outputs", {mem_addr, mem_rd, pc_inc, ainc_en, ainc_reg, ainc_step, src_op, dst_op,
                          dst_addr, dst_is_mem, busy, done}, 0);
    rst = 1'b0;
    step();
    set_in(0, 0, 4'd0, 4'd5, 2'd3, 0, 0, 0, 16'h0, 16'h0, 16'h0000, 16'h5555, 16'h1000);
    run("imm_mov", 16'h1234, 16'h5555, 16'h0, 0, 2, 1, 0, 1, 0);
    chk("imm_mov.rd_addr", rd_log[0], 16'h1000);
    chk("imm_mov.pc_after", pc_val, 16'h1002);
    set_in(0, 0, 4'd3, 4'd4, 2'd3, 0, 1, 0, 16'hFFFF, 16'h0, 16'h0000, 16'h0042, 16'h1100);
    run("cg_src", 16'hFFFF, 16'h0042, 16'h0, 0, 1, 0, 0, 0, 0);
    chk("cg_src.no_mem_rd", rd_cycles, 0);
    set_in(0, 1, 4'd6, 4'd7, 2'd3, 1, 0, 0, 16'h0, 16'h0, 16'h0200, 16'h0300, 16'h2000);
    run("autoinc_idx", 16'h00AB, 16'h7777, 16'h0310, 1, 4, 1, 1, 3, 0);
    chk("autoinc_idx.src_rd_addr", rd_log[0], 16'h0200);
    chk("autoinc_idx.dst_rd_addr", rd_log[2], 16'h0310);
    chk("autoinc_idx.ainc_reg", ai_reg, 4'd6);
    chk("autoinc_idx.ainc_step", ai_step, 2'd1);
    delay = 3;
    set_in(0, 0, 4'd2, 4'd8, 2'd1, 0, 0, 0, 16'h0, 16'h0, 16'h0007, 16'h0808, 16'h3000);
    run("abs_wait", 16'hBEEF, 16'h0808, 16'h0, 0, 9, 1, 0, 2, 1);
    chk("abs_wait.rd_addr", rd_log[1], 16'h0400);
    chk("abs_wait.held_cycles", rd_cycles, 8);
    chk("abs_wait.addr_stable", unstable, 0);
    delay = 0;
    set_in(0, 0, 4'd4, 4'd9, 2'd1, 0, 0, 0, 16'h0, 16'h0, 16'hFFFE, 16'h0909, 16'h4000);
    run("idx_wrap", 16'h2222, 16'h0909, 16'h0, 0, 3, 1, 0, 2, 0);
    chk("idx_wrap.rd_addr", rd_log[1], 16'h0002);
    set_in(1, 0, 4'd0, 4'd0, 2'd1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h5000, 16'h5000);
    run("f1_symbolic", 16'h0, 16'h5151, 16'h5100, 1, 3, 1, 0, 2, 0);
    set_in(1, 1, 4'd0, 4'd1, 2'd3, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0A00, 16'h0B00);
    run("f1_sp_autoinc", 16'h0, 16'h0AAA, 16'h0A00, 1, 2, 0, 1, 1, 0);
    chk("f1_sp_autoinc.ainc_reg", ai_reg, 4'd1);
    chk("f1_sp_autoinc.ainc_step", ai_step, 2'd2);
    set_in(0, 0, 4'd9, 4'd10, 2'd1, 1, 0, 0, 16'h0, 16'h0, 16'h0100, 16'h0200, 16'h6000);
    run("idx_idx", 16'h1111, 16'h2323, 16'h0230, 1, 5, 2, 0, 4, 1);
    chk("idx_idx.dst_ext_addr", rd_log[2], 16'h6002);
    set_in(0, 0, 4'd5, 4'd3, 2'd0, 1, 0, 1, 16'h0, 16'h0008, 16'h1357, 16'h0, 16'h7000);
    run("dst_cg", 16'h1357, 16'h0008, 16'h0, 0, 1, 0, 0, 0, 0);
    delay = 20;
    pc_cnt = 0; ai_cnt = 0;
    set_in(0, 0, 4'd6, 4'd5, 2'd3, 0, 0, 0, 16'h0, 16'h0, 16'h0700, 16'h0, 16'h7100);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("rst_mid.reading", {mem_rd, mem_addr}, {1'b1, 16'h0700});
    rst = 1'b1;
    step();
    chk("rst_mid.outputs", {mem_addr, mem_rd, pc_inc, ainc_en, ainc_reg, ainc_step, src_op, dst_op,
                            dst_addr, dst_is_mem, busy, done}, 0);
    rst = 1'b0;
    step();
    chk("rst_mid.no_done", {done_now, done, busy}, 0);
    chk("rst_mid.no_pulses", {pc_cnt[15:0], ai_cnt[15:0]}, 0);
    delay = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
